// File: rtl/pipelined_select_adder_pkg.sv
// Shared helpers for the pipelined carry-select adder: block count and
// elaboration-time configuration check.
package adder_pkg;

  function automatic int nblk(input int width, input int block);
    return width / block;
  endfunction

  // WIDTH must split into whole blocks, and blocks must spread evenly over stages.
  function automatic bit cfg_ok(input int width, input int block, input int stages);
    return (block > 0) && (stages > 0) && (width % block == 0) &&
           ((width / block) % stages == 0);
  endfunction

endpackage

// File: rtl/pipelined_select_adder_if.sv
// Operand/result handshake bundle for pipelined_select_adder.
interface adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ov;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, co, ov
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, co, ov
    );
endinterface

// File: rtl/pipelined_select_adder_select_block.sv
// One carry-select block: sums for carry-in 0 and 1 computed in parallel,
// then selected by the incoming block carry.
module select_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_c,
    output logic [BLOCK-1:0] o_s,
    output logic             o_co
);
    logic [BLOCK:0] w_r0;
    logic [BLOCK:0] w_r1;

    assign w_r0 = {1'b0, i_a} + {1'b0, i_b};
    assign w_r1 = {1'b0, i_a} + {1'b0, i_b} + {{BLOCK{1'b0}}, 1'b1};
    assign {o_co, o_s} = i_c ? w_r1 : w_r0;
endmodule

// File: rtl/pipelined_select_adder.sv
// Pipelined carry-select adder/subtractor; each register stage resolves an
// equal share of the blocks, with valid/ready chaining between stages.
module pipelined_select_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    adder_if.slave io
);
    localparam int NBLK = nblk(WIDTH, BLOCK);
    localparam int BPS  = NBLK / STAGES;
    localparam int MSB  = WIDTH - 1;

    // sum: resolved low bits; c: carry into the next unresolved block;
    // a/b: effective operands still needed downstream (MSBs feed OV).
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pl_t;

    if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_cfg
        $error("pipelined_select_adder: WIDTH/BLOCK/STAGES do not partition evenly");
    end

    pl_t w_in;
    assign w_in = '{sum: '0, c: io.cin ^ io.sub, a: io.a, b: io.b ^ {WIDTH{io.sub}}};

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int SLO = s * BPS * BLOCK;

        pl_t                        w_src;
        pl_t                        w_nx;
        pl_t                        r_pl;
        logic                       r_vld;
        logic                       w_up;
        logic                       w_ld;
        logic [BPS-1:0][BLOCK-1:0]  w_bs;

        if (s == 0) begin : g_head
            assign w_src = w_in;
            assign w_up  = io.in_valid;
        end else begin : g_body
            assign w_src = g_stg[s-1].r_pl;
            assign w_up  = g_stg[s-1].r_vld;
        end

        // A stage may take a new beat when it is empty or its occupant leaves.
        if (s == STAGES - 1) begin : g_tail_ld
            assign w_ld = !r_vld || io.out_ready;
        end else begin : g_mid_ld
            assign w_ld = !r_vld || g_stg[s+1].w_ld;
        end

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            localparam int K  = s * BPS + j;
            localparam int LO = K * BLOCK;

            logic             w_ci;
            logic             w_co;
            logic [BLOCK-1:0] w_s;

            if (j == 0) begin : g_ci_stage
                assign w_ci = w_src.c;
            end else begin : g_ci_chain
                assign w_ci = g_blk[j-1].w_co;
            end

            if (K == 0) begin : g_ripple
                assign {w_co, w_s} = {1'b0, w_src.a[LO +: BLOCK]} +
                                     {1'b0, w_src.b[LO +: BLOCK]} +
                                     {{BLOCK{1'b0}}, w_ci};
            end else begin : g_select
                select_block #(.BLOCK(BLOCK)) u_sel (
                    .i_a  (w_src.a[LO +: BLOCK]),
                    .i_b  (w_src.b[LO +: BLOCK]),
                    .i_c  (w_ci),
                    .o_s  (w_s),
                    .o_co (w_co)
                );
            end

            assign w_bs[j] = w_s;
        end

        always_comb begin
            w_nx                       = w_src;
            w_nx.sum[SLO +: BPS*BLOCK] = w_bs;
            w_nx.c                     = g_blk[BPS-1].w_co;
        end

        // Payload loads only on a real transfer; bubbles keep stale data.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_vld <= 1'b0;
                r_pl  <= '0;
            end else if (w_ld) begin
                r_vld <= w_up;
                if (w_up) r_pl <= w_nx;
            end
        end
    end

    pl_t  w_last;
    logic w_unused_ab;

    assign w_last       = g_stg[STAGES-1].r_pl;
    assign w_unused_ab  = ^{w_last.a[MSB-1:0], w_last.b[MSB-1:0]};

    assign io.in_ready  = g_stg[0].w_ld;
    assign io.out_valid = g_stg[STAGES-1].r_vld;
    assign io.sum       = w_last.sum;
    assign io.co        = w_last.c;
    assign io.ov        = (w_last.a[MSB] == w_last.b[MSB]) && (w_last.sum[MSB] != w_last.a[MSB]);
endmodule

// File: tb/tb_pipelined_select_adder.sv
// Directed and randomized bench for pipelined_select_adder (16/4/2) against a
// signed/unsigned arithmetic reference model.
module tb_pipelined_select_adder;
    logic clk;
    logic rst_n;

    adder_if #(.WIDTH(16)) bus ();

    pipelined_select_adder #(.WIDTH(16), .BLOCK(4), .STAGES(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ov;
        bit          lit;
        logic [15:0] lsum;
        logic        lco;
        logic        lov;
        bit          lat;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    bit          rnd_or = 0;
    bit          prev_stall = 0;
    logic [17:0] prev_out;

    bit          cur_lit, cur_lat;
    logic [15:0] cur_lsum;
    logic        cur_lco, cur_lov;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: true integer result; CO = carry (add) / no-borrow (sub),
    // OV = signed result outside the 16-bit range.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic c);
        int u, sr;
        logic co, ov;
        if (!s) begin
            u  = int'(a) + int'(b) + int'(c);
            sr = int'($signed(a)) + int'($signed(b)) + int'(c);
            co = (u > 65535);
        end else begin
            u  = int'(a) - int'(b) - int'(c);
            sr = int'($signed(a)) - int'($signed(b)) - int'(c);
            co = (u >= 0);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, u[15:0]};
    endfunction

    always @(negedge rst_n) q.delete();

    always @(negedge clk) begin
        exp_t e;
        logic [17:0] m;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("model_out", {14'd0, bus.ov, bus.co, bus.sum}, {14'd0, e.ov, e.co, e.sum});
                    if (e.lit)
                        chk("literal_out", {14'd0, bus.ov, bus.co, bus.sum}, {14'd0, e.lov, e.lco, e.lsum});
                    if (e.lat) chk("latency", cyc - e.cyc, 32'd2);
                end
            end
            if (prev_stall)
                chk("stall_hold", {14'd0, bus.ov, bus.co, bus.sum}, {14'd0, prev_out});
            if (bus.in_valid && bus.in_ready) begin
                m = model(bus.a, bus.b, bus.sub, bus.cin);
                e = '{sum: m[15:0], co: m[16], ov: m[17], lit: cur_lit, lsum: cur_lsum,
                      lco: cur_lco, lov: cur_lov, lat: cur_lat, cyc: cyc};
                q.push_back(e);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.ov, bus.co, bus.sum};
        end else begin
            prev_stall = 0;
        end
        cyc++;
    end

    always @(posedge clk) if (rnd_or) #1 bus.out_ready = 1'($urandom_range(0, 1));

    // Callers enter just after a rising edge.
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic c, input bit lit, input logic [15:0] es,
                         input logic eco, input logic eov, input bit lat);
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.sub = s; bus.cin = c;
        cur_lit = lit; cur_lsum = es; cur_lco = eco; cur_lov = eov; cur_lat = lat;
    endtask

    task automatic finish_beat();
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic c, input bit lit, input logic [15:0] es,
                        input logic eco, input logic eov, input bit lat);
        drive(a, b, s, c, lit, es, eco, eov, lat);
        finish_beat();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
        cur_lit = 0; cur_lat = 0; cur_lsum = '0; cur_lco = 0; cur_lov = 0;
        #1;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_sum", {16'd0, bus.sum}, 32'd0);
        chk("reset_co_ov", {30'd0, bus.co, bus.ov}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Carry ripples through every block; result visible for exactly one cycle.
        send(16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000, 1, 0, 1);
        @(negedge clk); chk("t1_not_yet", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk); chk("t1_valid",   {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk); chk("t1_one_cyc", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;

        send(16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1, 1);
        send(16'h1234, 16'h4321, 0, 1, 1, 16'h5556, 0, 0, 1);
        send(16'h0005, 16'h0007, 1, 0, 1, 16'hFFFE, 0, 0, 1);
        send(16'h8000, 16'h0001, 1, 0, 1, 16'h7FFF, 1, 1, 1);
        send(16'h0010, 16'h0001, 1, 1, 1, 16'h000E, 1, 0, 1);
        repeat (4) @(posedge clk); #1;

        // Backpressure: two beats fill the pipe, then in_ready must drop.
        bus.out_ready = 1'b0;
        send(16'd1, 16'd1, 0, 0, 1, 16'd2, 0, 0, 0);
        send(16'd2, 16'd2, 0, 0, 1, 16'd4, 0, 0, 0);
        drive(16'd3, 16'd3, 0, 0, 1, 16'd6, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
            chk("t4_stall_sum", {15'd0, bus.out_valid, bus.sum}, {15'd0, 1'b1, 16'd2});
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        finish_beat();
        send(16'd4, 16'd4, 0, 0, 1, 16'd8, 0, 0, 0);
        repeat (4) @(posedge clk); #1;
        chk("t4_drained", q.size(), 32'd0);

        // Reset with two beats in flight.
        bus.out_ready = 1'b0;
        send(16'h0100, 16'h0200, 0, 0, 1, 16'h0300, 0, 0, 0);
        send(16'h0400, 16'h0500, 0, 0, 1, 16'h0900, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_sum", {16'd0, bus.sum}, 32'd0);
        chk("t6_rst_co_ov", {30'd0, bus.co, bus.ov}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; bus.out_ready = 1'b1;
        chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_stale", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send(16'hABCD, 16'h1111, 1, 0, 1, 16'h9ABC, 1, 0, 1);
        repeat (3) @(posedge clk); #1;

        // Random traffic with random backpressure.
        rnd_or = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 0, 16'd0, 0, 0, 0);
        end
        rnd_or = 0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("final_drain", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/pipelined_select_adder.md
# pipelined_select_adder

Parametrised, pipelined carry-select adder/subtractor with valid/ready handshaking on both sides. Splits a WIDTH-bit operation into BLOCK-bit carry-select blocks spread evenly across STAGES register stages. It serves as the general-purpose arithmetic datapath for the lab ALU and multiplier accumulation paths, replacing fixed 16-bit combinational adders wherever throughput or timing closure matters.

## Interface
- WIDTH, 16: operand and sum width; must be a multiple of BLOCK.
- BLOCK, 4: bits per carry-select block.
- STAGES, 2: register stages (latency); NBLK = WIDTH/BLOCK, and NBLK % STAGES must be 0.

- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Sub  in  1  0 = A+B+Cin; 1 = A−B−Cin (Cin acts as borrow-in)
- Cin  in  1  carry-in (add) / borrow-in (sub)
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- Sum  out  WIDTH  result
- CO  out  1  raw carry out of MSB (in sub mode, 1 = no borrow)
- OV  out  1  two's-complement signed overflow

## Operation
- Effective B is B ^ {WIDTH{Sub}`}. Carry into bit 0 is Cin ^ Sub.
- Block 0 is a plain BLOCK-bit ripple adder. Every other block computes sums with carry-in 0 and with carry-in 1, then muxes on the incoming block carry.
- Stage s (0..STAGES−1) resolves blocks s·NBLK/STAGES through (s+1)·NBLK/STAGES−1. Its register holds: valid bit, resolved low sum bits, carry into the next unresolved block, unresolved A/B-effective bits, and the MSB operand signs needed for OV.
- OV = (Aeff[MSB] == Beff[MSB]) && (Sum[MSB] != Aeff[MSB]), where Aeff = A and Beff is the effective B.
- Handshake uses per-stage valid with ready chaining: stage k may load when it is empty or stage k+1 loads this cycle. The last stage may load when it is empty or out_ready is high. in_ready is stage 0's load condition.
- A beat transfers when valid && ready. Beats are never dropped, duplicated or reordered.
- Sum, CO and OV come from the last stage register. They hold stable while out_valid && !out_ready.

## Timing
- Latency is exactly STAGES cycles from the input transfer edge to out_valid high, with no stall.
- Throughput is 1 beat/cycle while out_ready stays high.
- Full pipeline with out_ready=1: in_ready=1, and one beat enters and one leaves in the same cycle.
- Full pipeline with out_ready=0: in_ready=0. Internal bubbles compact: an empty stage accepts from upstream even while downstream is stalled.
- in_ready depends combinationally on out_ready. No combinational path exists from A/B to Sum.
- Reset_n low takes effect immediately (asynchronous): all valid bits = 0, out_valid = 0, Sum = 0, CO = 0, OV = 0, in_ready = 1 once released.
- Reset mid-operation discards in-flight beats. No result appears for them.
- Operand and data registers load only on transfer. Bubble stages keep stale data, which is invisible because valid = 0.

## Structure
- Package adder_pkg holds:
  - function nblk(WIDTH, BLOCK)
  - the elaboration-time parameter checks, as assertion macros/constants
  - the stage-payload struct parametrised via localparams in the module.
- Sub-module select_block (BLOCK-bit, dual carry-in sums plus carry mux, combinational) is instantiated NBLK−1 times.
- The top contains the generate loop over stages and the handshake logic.

## Test plan
All scenarios use WIDTH=16, BLOCK=4, STAGES=2.
1. 0xFFFF + 0x0001, Sub=0, Cin=0 -> two cycles later Sum=0x0000, CO=1, OV=0, out_valid=1 for one cycle with out_ready=1.
2. 0x7FFF + 0x0001 -> Sum=0x8000, CO=0, OV=1; 0x1234 + 0x4321 with Cin=1 -> Sum=0x5556, CO=0, OV=0.
3. Sub=1: 0x0005 − 0x0007, Cin=0 -> Sum=0xFFFE, CO=0, OV=0; 0x8000 − 0x0001 -> Sum=0x7FFF, CO=1, OV=1; 0x0010 − 0x0001 with Cin=1 -> Sum=0x000E.
4. Stream 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) with out_ready held low from cycle 1 to 4 -> in_ready falls after 2 beats are accepted. After release, outputs are 2, 4, 6, 8 in order with none lost. Sum stays stable during the stall.
5. Random out_ready and in_valid over 10k beats, compared against a reference model A ± B ± Cin -> exact match for Sum/CO/OV and ordering.
6. Assert Reset_n low while 2 beats are in flight -> out_valid=0 and Sum=0 immediately. After release, no stale beat emerges and the next beat has latency 2.
